// File: rtl/jpeg_byte_streamer.sv
// jpeg_byte_streamer: buffers 32-bit encoder words in a small FIFO and
// re-emits them as a byte stream, flagging the last byte of each image and
// reporting frame size, overflow and address-sequence errors.
//
// Handshake (byte output): a byte transfers on a rising clk edge where
// out_valid & out_ready are both 1. Once out_valid is raised, out_data,
// out_valid and out_last stay constant until that transfer happens; out_valid
// never depends combinationally on out_ready. The word input has no
// backpressure: in_valid is a one-cycle strobe that is either stored or dropped.
//
// The word under serialization stays in the FIFO (at the read pointer) until
// its byte 3 is accepted, so the FIFO depth bounds all words held by the block.
module jpeg_byte_streamer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       in_data,
    input  logic [ADDR_W-1:0] in_address,
    input  logic              in_valid,
    input  logic              in_image_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   frame_bytes,
    output logic              frame_done,
    output logic              overflow,
    output logic              seq_error,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = ADDR_W - 1;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;

    // Word FIFO storage and bookkeeping
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   unserved;
    logic             full;

    // Serializer state
    logic [31:0]      cur_word;
    logic [1:0]       byte_idx;
    logic             word_last;

    // Frame bookkeeping
    logic [ADDR_W-1:0] exp_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  total_words;
    logic              img_prev;

    // Control strobes
    logic             img_rise;
    logic             accept;
    logic             finish;
    logic             load_ok;
    logic             load;
    logic             load_last;
    logic [PTR_W-1:0] load_idx;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;

    assign dbg_state = state;
    assign out_data  = cur_word[{byte_idx, 3'b000} +: 8];

    // Words behind the one currently being serialized
    assign unserved = count - {{PTR_W{1'b0}}, out_valid};
    assign full     = (count == CNT_FULL);
    assign img_rise = in_image_valid & ~img_prev;

    assign accept   = out_valid & out_ready;
    assign finish   = accept & (byte_idx == 2'd3);
    assign pop      = finish;

    // While streaming one word is always held back so the final word of the
    // image is only known once in_image_valid arrives.
    assign load_ok   = ((state == STREAM) && (unserved >= CNT_TWO)) ||
                       ((state == DRAIN)  && (unserved >= CNT_ONE));
    assign load      = load_ok & (~out_valid | finish);
    assign load_idx  = out_valid ? rd_ptr + 1'b1 : rd_ptr;
    assign load_last = (state == DRAIN) && (unserved == CNT_ONE);

    assign push_req = in_valid & (((state == IDLE) && (in_address == '0)) ||
                                  (state == STREAM));
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // FIFO storage write (data array needs no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Byte serializer: loads a word, steps through its four bytes on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_word  <= '0;
            byte_idx  <= 2'd0;
            word_last <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            cur_word  <= mem[load_idx];
            byte_idx  <= 2'd0;
            word_last <= load_last;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (finish) begin
            byte_idx  <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            byte_idx  <= byte_idx + 1'b1;
            out_last  <= word_last & (byte_idx == 2'd2);
        end
    end

    // Frame control FSM with registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            img_prev    <= 1'b0;
            exp_addr    <= '0;
            word_cnt    <= '0;
            total_words <= '0;
            frame_bytes <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            img_prev   <= in_image_valid;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_address == '0) begin
                            overflow  <= 1'b0;
                            seq_error <= 1'b0;
                            exp_addr  <= ADDR_W'(4);
                            word_cnt  <= CNT_W'(1);
                            state     <= STREAM;
                        end else begin
                            seq_error <= 1'b1;
                        end
                    end else if (img_rise) begin
                        frame_bytes <= '0;
                        frame_done  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (in_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                        exp_addr <= in_address + ADDR_W'(4);
                        if (in_address != exp_addr) begin
                            seq_error <= 1'b1;
                        end
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    if (img_rise) begin
                        total_words <= word_cnt + {{(CNT_W-1){1'b0}}, in_valid};
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        seq_error <= 1'b1;
                    end
                    if ((finish && word_last) || (count == '0)) begin
                        frame_bytes <= {total_words, 2'b00};
                        frame_done  <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_byte_streamer.sv
// Directed bench for jpeg_byte_streamer: basic frame, stalled output,
// overflow, address errors, empty frame and mid-frame reset.
module tb_jpeg_byte_streamer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [31:0]       in_data;
    logic [ADDR_W-1:0] in_address;
    logic              in_valid;
    logic              in_image_valid;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ADDR_W:0]   frame_bytes;
    logic              frame_done;
    logic              overflow;
    logic              seq_error;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // monitor state
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt;
    bit         valid_seen;
    bit         first_seen;
    int         first_valid_cyc;

    jpeg_byte_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_data       (in_data),
        .in_address    (in_address),
        .in_valid      (in_valid),
        .in_image_valid(in_image_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .frame_bytes   (frame_bytes),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .seq_error     (seq_error),
        .dbg_state     (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // capture accepted bytes and frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
        end
        if (out_valid) begin
            valid_seen = 1'b1;
            if (!first_seen) begin
                first_seen      = 1'b1;
                first_valid_cyc = cyc;
            end
        end
        if (frame_done) done_cnt++;
    end

    task clear_mon();
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        done_cnt        = 0;
        valid_seen      = 1'b0;
        first_seen      = 1'b0;
        first_valid_cyc = -1;
    endtask

    task push_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        in_address = a;
        in_data    = d;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    task wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task test_reset();
        resetn = 1'b0; in_data = '0; in_address = '0; in_valid = 1'b0;
        in_image_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (frame_bytes !== '0) begin bad++; $display("FAIL reset_frame_bytes got=%0d exp=0", frame_bytes); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL reset_seq_error got=%b exp=0", seq_error); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task test_basic();
        bit ok;
        int e;
        clear_mon();
        out_ready = 1'b1;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC};
        push_word(16'd0, 32'h44332211);
        push_word(16'd4, 32'h88776655);
        e = cyc;
        push_word(16'd8, 32'hCCBBAA99);
        in_image_valid = 1'b1;
        wait_done(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=none exp=frame_done"); end
        total++; if (first_valid_cyc !== e + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", first_valid_cyc, e + 1); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL basic_byte%0d got=%h last=%b exp=%h last=%b", k,
                         (k < got_q.size()) ? got_q[k] : 8'hxx,
                         (k < got_q.size()) ? got_last_q[k] : 1'bx, exp_q[k], (k == exp_q.size() - 1));
            end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        total++; if (frame_bytes !== 17'd12) begin bad++; $display("FAIL basic_frame_bytes got=%0d exp=12", frame_bytes); end
        total++; if (seq_error !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b exp=00", seq_error, overflow); end
        in_image_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task test_stall();
        bit stall_prev;
        logic [7:0] held_d;
        logic held_l;
        bit ok;
        clear_mon();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC};
        stall_prev = 1'b0; held_d = '0; held_l = 1'b0; ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            in_valid       = (i < 3);
            in_address     = 16'(4 * i);
            in_data        = (i == 0) ? 32'h44332211 : (i == 1) ? 32'h88776655 : 32'hCCBBAA99;
            in_image_valid = (i >= 3);
            out_ready      = (i % 2 == 0);
            @(negedge clk);
            if (stall_prev) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    bad++;
                    $display("FAIL stall_hold cyc%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0; in_image_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=none exp=frame_done"); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL stall_byte%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        total++; if (frame_bytes !== 17'd12 || done_cnt !== 1) begin bad++; $display("FAIL stall_frame got=%0d/%0d exp=12/1", frame_bytes, done_cnt); end
    endtask

    task test_overflow();
        bit ok;
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_word(16'(4 * i), {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
            if (i == DEPTH - 1) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
            end
            if (i == DEPTH) begin
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
            end
        end
        for (int k = 0; k < 4 * DEPTH; k++) exp_q.push_back(8'(k));
        in_image_valid = 1'b1;
        out_ready = 1'b1;
        wait_done(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_done_timeout got=none exp=frame_done"); end
        total++; if (frame_bytes !== 17'((DEPTH + 2) * 4)) begin bad++; $display("FAIL ovf_frame_bytes got=%0d exp=%0d", frame_bytes, (DEPTH + 2) * 4); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL ovf_byte%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        in_image_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task test_seq_error();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                  8'h18, 8'h19, 8'h1A, 8'h1B};
        push_word(16'd0, 32'h13121110);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL seq_ovf_cleared got=%b exp=0", overflow); end
        push_word(16'd4, 32'h17161514);
        total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL seq_early got=%b exp=0", seq_error); end
        push_word(16'd12, 32'h1B1A1918);
        total++; if (seq_error !== 1'b1) begin bad++; $display("FAIL seq_set got=%b exp=1", seq_error); end
        in_image_valid = 1'b1;
        wait_done(100, ok);
        in_image_valid = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL seq_done_timeout got=none exp=frame_done"); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL seq_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL seq_byte%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        total++; if (frame_bytes !== 17'd12) begin bad++; $display("FAIL seq_frame_bytes got=%0d exp=12", frame_bytes); end
        // single-word frame at address 0 clears the error
        clear_mon();
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(posedge clk); #1;
        push_word(16'd0, 32'hDDCCBBAA);
        total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL seq_cleared got=%b exp=0", seq_error); end
        in_image_valid = 1'b1;
        wait_done(100, ok);
        in_image_valid = 1'b0;
        total++; if (!ok || frame_bytes !== 17'd4) begin bad++; $display("FAIL seq_single_frame got=%0d ok=%b exp=4", frame_bytes, ok); end
        total++; if (got_q.size() !== 4 || got_q[0] !== 8'hAA || got_q[3] !== 8'hDD || got_last_q[3] !== 1'b1 || got_last_q[2] !== 1'b0) begin
            bad++; $display("FAIL seq_single_bytes got_n=%0d exp_n=4", got_q.size());
        end
        // nonzero address while idle is ignored but flagged
        clear_mon();
        @(posedge clk); #1;
        push_word(16'd8, 32'h55555555);
        repeat (6) @(posedge clk); #1;
        total++; if (seq_error !== 1'b1) begin bad++; $display("FAIL seq_idle_flag got=%b exp=1", seq_error); end
        total++; if (dbg_state !== 2'd0 || valid_seen !== 1'b0) begin bad++; $display("FAIL seq_idle_ignored state=%0d valid_seen=%b exp=0/0", dbg_state, valid_seen); end
    endtask

    task test_empty_frame();
        clear_mon();
        in_image_valid = 1'b1;
        repeat (8) @(posedge clk); #1;
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL empty_done_pulses got=%0d exp=1", done_cnt); end
        total++; if (frame_bytes !== '0) begin bad++; $display("FAIL empty_frame_bytes got=%0d exp=0", frame_bytes); end
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL empty_out_valid got=%b exp=0", valid_seen); end
        in_image_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task test_mid_reset();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        push_word(16'd0, 32'hA3A2A1A0);
        push_word(16'd8, 32'hA7A6A5A4);
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || seq_error !== 1'b1) begin bad++; $display("FAIL rst_precond got=%b%b exp=11", out_valid, seq_error); end
        resetn = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin bad++; $display("FAIL rst_out got=%b/%h/%b exp=0/00/0", out_valid, out_data, out_last); end
        total++; if (seq_error !== 1'b0 || overflow !== 1'b0 || frame_bytes !== '0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL rst_status got=%b%b/%0d/%0d exp=00/0/0", seq_error, overflow, frame_bytes, dbg_state);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt); end
        clear_mon();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_word(16'd0, 32'h04030201);
        push_word(16'd4, 32'h08070605);
        in_image_valid = 1'b1;
        wait_done(100, ok);
        in_image_valid = 1'b0;
        total++; if (!ok || done_cnt !== 1) begin bad++; $display("FAIL rst_frame_done got=%0d exp=1", done_cnt); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL rst_byte%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        total++; if (frame_bytes !== 17'd8 || seq_error !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rst_final got=%0d/%b%b exp=8/00", frame_bytes, seq_error, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_seq_error();
        test_empty_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
